// File: rtl/sev_seg_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sev_seg_scanner
//  Purpose  : Multiplexed N-digit hex seven-segment driver with frame-
//             synchronous shadowing, leading-zero blanking, per-digit decimal
//             points and PWM brightness.
//  Revision : 1.0 - initial release
// ============================================================================
module sev_seg_scanner #(
    parameter int N_DIGITS = 8,
    parameter int CLK_HZ   = 100_000_000,
    parameter int DIGIT_HZ = 500,
    parameter int BRIGHT_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [N_DIGITS-1:0]   anode_select,
    output logic [6:0]            segs,
    output logic                  dp,
    output logic                  frame_done
);

    // Slot length and derived widths; the on-time threshold is computed wide
    // enough that (brightness+1)*DIV never truncates.
    localparam int c_div   = CLK_HZ / DIGIT_HZ;
    localparam int c_div_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int c_idx_w = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int c_on_w  = BRIGHT_W + c_div_w + 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N_DIGITS - 1);

    // Scan state
    logic [c_div_w-1:0]    div_q, div_d;
    logic [c_idx_w-1:0]    idx_q, idx_d;

    // Shadow copies of the inputs, refreshed only at frame boundaries
    logic [4*N_DIGITS-1:0] value_s_q, value_s_d;
    logic [N_DIGITS-1:0]   dp_s_q, dp_s_d;
    logic                  blank_s_q, blank_s_d;
    logic [BRIGHT_W-1:0]   bright_s_q, bright_s_d;

    // Registered outputs
    logic [N_DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]            segs_q, segs_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    // Combinational helpers
    logic                  w_tick;
    logic                  w_frame_end;
    logic [c_on_w-1:0]     w_prod;
    logic [c_on_w-1:0]     w_on_lim;
    logic                  w_on;
    logic [N_DIGITS-1:0]   w_blank;
    logic [3:0]            w_nibble;
    logic                  w_dp_sel;
    logic                  w_blank_sel;
    logic [6:0]            w_seg_dec;

    // Slot divider, digit index, frame boundary and shadow capture
    always_comb begin
        w_tick       = (div_q == c_div_last);
        w_frame_end  = w_tick && (idx_q == c_idx_last);
        div_d        = w_tick ? '0 : div_q + c_div_w'(1);
        idx_d        = idx_q;
        if (w_tick) begin
            idx_d = (idx_q == c_idx_last) ? '0 : idx_q + c_idx_w'(1);
        end
        value_s_d    = value_s_q;
        dp_s_d       = dp_s_q;
        blank_s_d    = blank_s_q;
        bright_s_d   = bright_s_q;
        if (w_frame_end) begin
            value_s_d  = value;
            dp_s_d     = dp_in;
            blank_s_d  = blank_lz;
            bright_s_d = brightness;
        end
        frame_done_d = w_frame_end;
    end

    // PWM on-window: lit while div < ((brightness+1)*DIV) >> BRIGHT_W
    always_comb begin
        w_prod   = (c_on_w'(bright_s_q) + c_on_w'(1)) * c_on_w'(c_div);
        w_on_lim = w_prod >> BRIGHT_W;
        w_on     = (c_on_w'(div_q) < w_on_lim);
    end

    // Leading-zero blanking: digit i dark when it and every higher nibble is zero
    always_comb begin
        logic zeros;
        zeros   = 1'b1;
        w_blank = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            zeros = 1'b1;
            for (int j = 0; j < N_DIGITS; j++) begin
                if (j >= i && value_s_q[4*j +: 4] != 4'h0) begin
                    zeros = 1'b0;
                end
            end
            w_blank[i] = blank_s_q && (i != 0) && zeros && !dp_s_q[i];
        end
    end

    // Select the active digit's nibble, decimal point and blank flag
    always_comb begin
        w_nibble    = 4'h0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == c_idx_w'(i)) begin
                w_nibble    = value_s_q[4*i +: 4];
                w_dp_sel    = dp_s_q[i];
                w_blank_sel = w_blank[i];
            end
        end
    end

    // Hex to active-low gfedcba
    always_comb begin
        case (w_nibble)
            4'h0:    w_seg_dec = 7'b1000000;
            4'h1:    w_seg_dec = 7'b1111001;
            4'h2:    w_seg_dec = 7'b0100100;
            4'h3:    w_seg_dec = 7'b0110000;
            4'h4:    w_seg_dec = 7'b0011001;
            4'h5:    w_seg_dec = 7'b0010010;
            4'h6:    w_seg_dec = 7'b0000010;
            4'h7:    w_seg_dec = 7'b1111000;
            4'h8:    w_seg_dec = 7'b0000000;
            4'h9:    w_seg_dec = 7'b0010000;
            4'hA:    w_seg_dec = 7'b0001000;
            4'hB:    w_seg_dec = 7'b0000011;
            4'hC:    w_seg_dec = 7'b1000110;
            4'hD:    w_seg_dec = 7'b0100001;
            4'hE:    w_seg_dec = 7'b0000110;
            default: w_seg_dec = 7'b0001110;
        endcase
    end

    // Next output values; a single anode is chosen so two can never be low
    always_comb begin
        anode_d = '1;
        segs_d  = 7'h7F;
        dp_d    = 1'b1;
        if (w_on && !w_blank_sel) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (idx_q == c_idx_w'(i)) begin
                    anode_d[i] = 1'b0;
                end
            end
            segs_d = w_seg_dec;
            dp_d   = ~w_dp_sel;
        end
    end

    // State, shadow and output registers with asynchronous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q        <= '0;
            idx_q        <= '0;
            value_s_q    <= '0;
            dp_s_q       <= '0;
            blank_s_q    <= 1'b0;
            bright_s_q   <= '0;
            anode_q      <= '1;
            segs_q       <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            value_s_q    <= value_s_d;
            dp_s_q       <= dp_s_d;
            blank_s_q    <= blank_s_d;
            bright_s_q   <= bright_s_d;
            anode_q      <= anode_d;
            segs_q       <= segs_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anode_select = anode_q;
    assign segs         = segs_q;
    assign dp           = dp_q;
    assign frame_done   = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sev_seg_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sev_seg_scanner
//  Purpose  : Self-checking bench for sev_seg_scanner (8 digits, 16-cycle slot)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sev_seg_scanner;

    localparam int N        = 8;
    localparam int CLK_HZ   = 1600;
    localparam int DIGIT_HZ = 100;
    localparam int BW       = 4;
    localparam int DIV      = CLK_HZ / DIGIT_HZ;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  brightness = '0;
    logic [7:0]  anode_select;
    logic [6:0]  segs;
    logic        dp;
    logic        frame_done;

    always #5 clock = ~clock;

    sev_seg_scanner #(
        .N_DIGITS (N),
        .CLK_HZ   (CLK_HZ),
        .DIGIT_HZ (DIGIT_HZ),
        .BRIGHT_W (BW)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .value        (value),
        .dp_in        (dp_in),
        .blank_lz     (blank_lz),
        .brightness   (brightness),
        .anode_select (anode_select),
        .segs         (segs),
        .dp           (dp),
        .frame_done   (frame_done)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] sg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference decode table, gfedcba active-low
    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model state (state that the next edge acts upon)
    int          m_div, m_idx;
    logic [31:0] s_val;
    logic [7:0]  s_dp;
    logic        s_blank;
    logic [3:0]  s_bright;

    // Last sampled outputs and per-frame summaries
    logic [7:0]  obs_an;
    logic [6:0]  obs_seg;
    logic        obs_dp, obs_fd;
    logic [15:0] lit_mask [8];
    logic [7:0]  slot_an  [8];
    logic [6:0]  slot_seg [8];
    logic        slot_dp  [8];
    int          fd_cnt, fd_pos;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_div = 0; m_idx = 0;
        s_val = '0; s_dp = '0; s_blank = 1'b0; s_bright = '0;
    endtask

    // Predict the outputs the coming edge produces and push them
    task automatic push_expect();
        exp_t       e;
        logic       zeros, lit, on;
        logic [2:0] ix;
        logic [3:0] nib;
        if (!reset) begin
            e.an = 8'hFF; e.sg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0;
            model_reset();
        end else begin
            ix    = 3'(m_idx);
            nib   = 4'(s_val >> (4 * m_idx));
            zeros = 1'b1;
            for (int j = 0; j < N; j++)
                if (j >= m_idx && 4'(s_val >> (4 * j)) != 4'h0) zeros = 1'b0;
            lit = !(s_blank && m_idx != 0 && zeros && !s_dp[ix]);
            on  = (m_div < (((int'(s_bright) + 1) * DIV) >> BW));
            if (on && lit) begin
                e.an = ~(8'h01 << ix); e.sg = seg_tab[nib]; e.dp = ~s_dp[ix];
            end else begin
                e.an = 8'hFF; e.sg = 7'h7F; e.dp = 1'b1;
            end
            e.fd = (m_div == DIV - 1 && m_idx == N - 1);
            if (e.fd) begin
                s_val = value; s_dp = dp_in; s_blank = blank_lz; s_bright = brightness;
            end
            if (m_div == DIV - 1) begin
                m_div = 0; m_idx = (m_idx + 1) % N;
            end else begin
                m_div++;
            end
        end
        sb_q.push_back(e);
    endtask

    // One clock: predict, advance, sample #1 later, compare
    task automatic step();
        exp_t e;
        push_expect();
        @(posedge clock);
        #1;
        obs_an = anode_select; obs_seg = segs; obs_dp = dp; obs_fd = frame_done;
        e = sb_q.pop_front();
        check("anode", 32'(obs_an), 32'(e.an));
        check("segs", 32'(obs_seg), 32'(e.sg));
        check("dp", 32'(obs_dp), 32'(e.dp));
        check("frame_done", 32'(obs_fd), 32'(e.fd));
    endtask

    task automatic run_to(input int idx, input int dv);
        int n;
        n = 0;
        while (!(m_idx == idx && m_div == dv) && n <= 300) begin
            step();
            n++;
        end
        checks++;
        assert (n <= 300) else begin
            errors++;
            $error("FAIL run_to: waited %0d cycles, limit 300", n);
        end
    endtask

    // Align to the next frame start, then record one whole frame
    task automatic run_frame();
        run_to(0, 0);
        fd_cnt = 0; fd_pos = -1;
        for (int k = 0; k < N; k++) begin
            lit_mask[k] = '0; slot_an[k] = 8'hFF; slot_seg[k] = 7'h7F; slot_dp[k] = 1'b1;
        end
        for (int s = 0; s < N * DIV; s++) begin
            step();
            if (obs_an != 8'hFF) begin
                lit_mask[s / DIV][s % DIV] = 1'b1;
                slot_an[s / DIV]  = obs_an;
                slot_seg[s / DIV] = obs_seg;
                slot_dp[s / DIV]  = obs_dp;
            end
            if (obs_fd) begin
                fd_cnt++; fd_pos = s;
            end
        end
    endtask

    logic [7:0] an_tab   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] scan_seg [8] = '{7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
                                 7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000};

    initial begin
        int n_ff;
        model_reset();

        // Reset held low while clocking
        repeat (5) step();
        check("rst_anode", 32'(anode_select), 32'hFF);
        check("rst_segs", 32'(segs), 32'h7F);
        reset = 1'b1;
        step();
        check("first_anode", 32'(obs_an), 32'hFE);
        check("first_segs", 32'(obs_seg), 32'(7'b1000000));
        check("first_dp", 32'(obs_dp), 32'h1);

        // Full scan/decode
        value = 32'h89AB_CDEF; brightness = 4'hF; blank_lz = 1'b0; dp_in = 8'h00;
        run_frame();
        run_frame();
        for (int k = 0; k < N; k++) begin
            check("scan_lit", 32'(lit_mask[k]), 32'hFFFF);
            check("scan_anode", 32'(slot_an[k]), 32'(an_tab[k]));
            check("scan_segs", 32'(slot_seg[k]), 32'(scan_seg[k]));
        end
        check("fd_count", 32'(fd_cnt), 32'd1);
        check("fd_pos", 32'(fd_pos), 32'd127);

        // Shadowing: value change mid-frame waits for the boundary
        value = 32'h0000_0001;
        run_frame();
        check("fd_count2", 32'(fd_cnt), 32'd1);
        check("fd_pos2", 32'(fd_pos), 32'd127);
        step();
        check("shadow_old", 32'(obs_seg), 32'(7'b1111001));
        run_to(3, 0);
        value = 32'h0000_0002;
        run_frame();
        check("shadow_new", 32'(slot_seg[0]), 32'(7'b0100100));
        check("shadow_d1", 32'(slot_seg[1]), 32'(7'b1000000));

        // Leading-zero blanking
        blank_lz = 1'b1; value = 32'h0000_0120;
        run_frame();
        run_frame();
        for (int k = 3; k < N; k++) check("lz_dark", 32'(lit_mask[k]), 32'h0);
        check("lz_d0", 32'(slot_seg[0]), 32'(7'b1000000));
        check("lz_d1", 32'(slot_seg[1]), 32'(7'b0100100));
        check("lz_d2", 32'(slot_seg[2]), 32'(7'b1111001));
        check("lz_d2_lit", 32'(lit_mask[2]), 32'hFFFF);
        value = 32'h0;
        run_frame();
        run_frame();
        check("lz0_d0", 32'(lit_mask[0]), 32'hFFFF);
        check("lz0_seg", 32'(slot_seg[0]), 32'(7'b1000000));
        for (int k = 1; k < N; k++) check("lz0_dark", 32'(lit_mask[k]), 32'h0);
        dp_in = 8'h10;
        run_frame();
        run_frame();
        check("lzdp_d4", 32'(lit_mask[4]), 32'hFFFF);
        check("lzdp_seg", 32'(slot_seg[4]), 32'(7'b1000000));
        check("lzdp_dp", 32'(slot_dp[4]), 32'h0);
        check("lzdp_d0dp", 32'(slot_dp[0]), 32'h1);
        check("lzdp_d3", 32'(lit_mask[3]), 32'h0);
        check("lzdp_d5", 32'(lit_mask[5]), 32'h0);

        // Brightness
        blank_lz = 1'b0; dp_in = 8'h00; value = 32'h1234_5678; brightness = 4'd3;
        run_frame();
        run_frame();
        for (int k = 0; k < N; k++) check("bright3", 32'(lit_mask[k]), 32'h000F);
        brightness = 4'hF;
        run_frame();
        run_frame();
        for (int k = 0; k < N; k++) check("brightF", 32'(lit_mask[k]), 32'hFFFF);

        // Asynchronous reset mid-slot
        run_to(5, 7);
        #2;
        reset = 1'b0;
        #1;
        check("arst_anode", 32'(anode_select), 32'hFF);
        check("arst_segs", 32'(segs), 32'h7F);
        check("arst_dp", 32'(dp), 32'h1);
        check("arst_fd", 32'(frame_done), 32'h0);
        model_reset();
        repeat (3) step();
        reset = 1'b1;
        step();
        check("rel_anode", 32'(obs_an), 32'hFE);
        n_ff = 0;
        repeat (15) begin
            step();
            if (obs_an == 8'hFF) n_ff++;
        end
        check("rel_slot_len", 32'(n_ff), 32'd15);
        step();
        check("rel_next", 32'(obs_an), 32'hFD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/sev_seg_scanner.md
Name: sev_seg_scanner

Overview:
Parametrised multiplexed seven-segment display driver for N hex digits.
- Generates its own digit-refresh tick, scans anodes and decodes hex to segments.
- Adds frame-synchronous value shadowing (no tearing), leading-zero blanking, per-digit decimal points and PWM brightness.
- Sits between counter/datapath logic and the board display pins; supersedes the fixed 8-digit scan chain.

Parameters:
N_DIGITS, 8, number of digits/anodes scanned (1..16)
CLK_HZ, 100_000_000, input clock frequency in Hz
DIGIT_HZ, 500, per-digit slot rate; slot length DIV = CLK_HZ/DIGIT_HZ cycles (DIV >= 2, exact integer)
BRIGHT_W, 4, brightness control width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
value  in  4*N_DIGITS  hex digits; nibble i (value[4i+3:4i]) shown on digit i, digit 0 least significant
dp_in  in  N_DIGITS  decimal point request per digit, 1 = lit
blank_lz  in  1  1 = suppress leading zeros
brightness  in  BRIGHT_W  on-time per slot; all-ones = full on
anode_select  out  N_DIGITS  active-low anode enables; at most one bit low
segs  out  7  active-low segments {g,f,e,d,c,b,a}
dp  out  1  active-low decimal point
frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (reset low, async):
  - Outputs: anode_select all ones, segs 7'h7F, dp 1, frame_done 0.
  - Internal state: divider 0, digit index 0, shadow value 0, shadow dp 0, shadow blank_lz 0, shadow brightness 0.
- Divider: counts 0..DIV-1 and wraps. tick = (div == DIV-1).
- Digit index: width clog2(N_DIGITS), minimum 1 bit.
  - On tick, index increments; it wraps from N_DIGITS-1 to 0.
  - N_DIGITS = 1 holds index at 0.
- Frame boundary = tick while index == N_DIGITS-1.
  - frame_done goes high the following cycle, for one cycle.
  - On the same edge, value, dp_in, blank_lz and brightness are captured into shadow registers.
  - All display logic uses shadow registers only, so input changes mid-frame are invisible until the next frame.
  - Power-up frame shows shadow reset values (all zeros).
- Slot on-time: on = (div < ((bright_s + 1) * DIV) >> BRIGHT_W).
  - Compute at BRIGHT_W + clog2(DIV) + 1 bits with no truncation.
  - With on = 0, anode_select is all ones, segs 7'h7F, dp 1.
- Leading-zero blanking: digit i is blanked when all of the following hold:
  - blank_s = 1;
  - i != 0;
  - nibbles i..N_DIGITS-1 of the shadow value are all zero;
  - dp_s[i] = 0.
  - A blanked digit drives its anode high for the whole slot.
- Output timing: outputs are registered, one cycle after the index/divider state that produces them.
  - Anode and segment changes occur on the same edge.
  - No cycle exists with two anodes low.
- Hex decode (active-low gfedcba):
  - 0=1000000 1=1111001 2=0100100 3=0110000
  - 4=0011001 5=0010010 6=0000010 7=1111000
  - 8=0000000 9=0010000 A=0001000 b=0000011
  - C=1000110 d=0100001 E=0000110 F=0001110
- dp = ~dp_s[index] while the digit is lit and on = 1, else 1.
- Reset asserted mid-frame clears everything immediately. After release, scanning restarts at digit 0 with div 0.

Test Plan:
Bench parameters unless stated: N_DIGITS=8, CLK_HZ=1600, DIGIT_HZ=100 (DIV=16), BRIGHT_W=4.
1. Reset: hold reset low, toggle the clock.
   -> anode_select=8'hFF, segs=7'h7F, dp=1, frame_done=0 throughout.
   -> After release, first frame shows digit0 "0" (segs 1000000) on anode 8'hFE.
   -> All other digits also show "0", since shadow blank_lz=0.
2. Scan/decode: value=32'h89AB_CDEF, brightness=4'hF, blank_lz=0, held across two frames.
   -> In frame 2, anode_select steps FE,FD,FB,F7,EF,DF,BF,7F, 16 cycles each.
   -> segs: F=0001110 on FE, E=0000110 on FD, ..., 8=0000000 on 7F.
   -> frame_done pulses every 128 cycles.
3. Shadowing: change value from 32'h0000_0001 to 32'h0000_0002 while index=3.
   -> Digit 0 keeps showing 1111001 until the next frame boundary, then shows 0100100.
4. Leading zeros: blank_lz=1, value=32'h0000_0120.
   -> Anodes stay high in slots 3..7; digits 2,1,0 show 1,2,0.
   -> With value=0, only digit 0 lit ("0").
   -> With value=0 and dp_in=8'h10, digit 4 is lit (segs 1000000, dp=0).
5. Brightness: brightness=3.
   -> Each slot's anode is low for exactly 4 of 16 cycles (div 0..3), high for 12.
   -> With brightness=4'hF, low for 16/16.
6. Async reset mid-frame: pull reset low at index 5, div 7, between clock edges.
   -> Outputs reach reset values before the next edge.
   -> After release, the scan restarts at anode 8'hFE with a full 16-cycle slot.
